spi_sipo_rx: RTL and testbench
==============================

// Module: spi_sipo_rx
// PURPOSE
//  Receive-side deserializer for the SPI interface and the counterpart of the transmit PISO.
//  - Samples an externally clocked SPI stream (sclk/cs_n/mosi), mode 0, MSB first.
//  - Assembles DATA_WIDTH-bit words.
//  - Hands each word downstream on a valid/ready port with a one-word holding register.
//  - Flags overrun and truncated frames.
// PARAMETERS
//  DATA_WIDTH   8  bits per word; bit counter width = $clog2(DATA_WIDTH)
//  SYNC_STAGES  2  flops in each input synchronizer (>=2)
// PORTS
//  clock      in   1           system clock; all logic on posedge
//  n_reset    in   1           asynchronous, active-low reset
//  sclk       in   1           SPI serial clock, async to clock; sclk freq <= clock/4
//  cs_n       in   1           SPI chip select, active low, async
//  mosi       in   1           SPI serial data, async; stable around sclk rise
//  rx_data    out  DATA_WIDTH  received word; valid while rx_valid=1
//  rx_valid   out  1           holding register full
//  rx_ready   in   1           consumer accepts word when rx_valid&rx_ready
//  busy       out  1           frame in progress (synchronized cs_n low)
//  overrun    out  1           sticky: word completed while holding register full
//  frame_err  out  1           one-cycle pulse: cs_n rose with partial word
//  clr_flags  in   1           synchronous clear of overrun
// BEHAVIOUR
//  Reset (n_reset=0, async): all outputs 0.
//   - Also cleared: synchronizers, shift register, bit counter, holding register.
//   - Synchronizers reset cs_n to 1 and sclk to 0.
//  Synchronization:
//   - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
//   - One extra flop per signal holds the previous value for edge detection.
//   - sclk_rise = sync_sclk & ~prev_sclk.
//   - cs_rise   = sync_cs_n & ~prev_cs_n.
//   - cs_fall   = ~sync_cs_n & prev_cs_n.
//  FSM, 2 states:
//   - IDLE: busy=0, bit counter held at 0. cs_fall -> SHIFT.
//   - SHIFT: busy=1.
//     - On each sclk_rise: shreg <= {shreg[DATA_WIDTH-2:0], sync_mosi}; cnt <= cnt+1.
//     - Sampled mosi is the synchronized copy aligned with sync_sclk.
//     - When cnt==DATA_WIDTH-1 and sclk_rise: the word completes. cnt wraps to 0 and the FSM
//       stays in SHIFT, so a multi-word frame is supported.
//     - cs_rise -> IDLE. If cnt!=0, pulse frame_err for 1 cycle and discard the partial word.
//     - If cs_rise and the final sclk_rise fall in the same cycle, the word completes
//       normally and frame_err stays 0.
//  Word completion, in the sclk_rise cycle:
//   - Holding register empty, or draining this cycle (rx_valid&rx_ready):
//     rx_data <= {shreg[DATA_WIDTH-2:0], sync_mosi} and rx_valid=1 on the next cycle.
//   - Otherwise the new word is dropped, rx_data/rx_valid are unchanged and overrun <= 1.
//  Latency:
//   - Pin sclk rise to rx_valid high = SYNC_STAGES+2 clocks.
//   - sclk high or low phases shorter than 2 clocks are not guaranteed to be sampled.
//  Handshake:
//   - rx_valid clears the cycle after rx_valid&rx_ready unless a new word loads in that
//     same cycle.
//   - rx_data is stable while rx_valid=1 and rx_ready=0.
//  overrun:
//   - Cleared only by clr_flags or reset.
//   - If clr_flags and a new overrun occur in the same cycle, the set wins.
//  sclk edges seen while in IDLE (cs_n high) are ignored.
//  Reset mid-frame: the partial word is lost; after release the block waits for a new cs_fall.
// TESTING
//  1. Reset then idle: rx_valid=0, busy=0, overrun=0, frame_err=0.
//  2. Single byte 0xA5 MSB first, rx_ready=1:
//     - rx_valid pulses one cycle with rx_data=0xA5.
//     - Pulse occurs SYNC_STAGES+2 clocks after the 8th sclk rise.
//  3. Three-word frame 0x3C,0xFF,0x01 under one cs_n low with rx_ready=1:
//     - Three accepted words in order; frame_err=0.
//  4. Two words with rx_ready=0 throughout:
//     - rx_data holds 0x11 and overrun=1 after the second word (0x22 dropped).
//     - clr_flags -> overrun=0.
//  5. cs_n rises after 5 sclk rises: one-cycle frame_err, no rx_valid, busy=0.
//     A following full frame carrying 0x5A is received correctly.
//  6. n_reset asserted after 4 bits of 0xC3:
//     - All outputs 0 immediately.
//     - A fresh frame 0x96 after release yields rx_data=0x96.

Source files
------------

// File: rtl/spi_sipo_rx.sv
// spi_sipo_rx: SPI mode-0 receive deserializer (MSB first).
// The three asynchronous SPI pins are synchronized into the system clock
// domain. Words are assembled in a shift register and handed downstream
// through a one-word valid/ready holding register. A sticky overrun flag
// marks dropped words, and a one-cycle frame_err pulse marks frames that end
// with a partial word.
module spi_sipo_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clr_flags
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchronizer chains plus one history flop each on sclk and cs_n
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [0:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic                  w_sclk_s;
  logic                  w_cs_s;
  logic                  w_mosi_s;
  logic                  w_sclk_rise;
  logic                  w_cs_rise;
  logic                  w_cs_fall;

  logic [0:0]            w_state_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-1:0] w_shreg_next;
  logic                  w_word_done;
  logic                  w_frame_err_next;
  logic                  w_drain;
  logic                  w_load;
  logic                  w_overrun_set;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;

  // Input synchronizers; cs_n resets to the inactive (high) level
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a chain a chain.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Frame FSM, bit counter and shift register next-state logic
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_shreg_next     = r_shreg;
    w_word_done      = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_cs_fall) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_sclk_rise) begin
          w_shreg_next = {r_shreg[DATA_WIDTH-2:0], w_mosi_s};
          if (r_cnt == CNT_LAST) begin
            w_cnt_next  = '0;
            w_word_done = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        // A final bit landing together with cs_n rise leaves the count at
        // zero, so that word completes cleanly without a frame error.
        if (w_cs_rise) begin
          w_state_next     = ST_IDLE;
          w_frame_err_next = (w_cnt_next != '0);
          w_cnt_next       = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_drain       = r_rx_valid & rx_ready;
  assign w_load        = w_word_done & (~r_rx_valid | w_drain);
  assign w_overrun_set = w_word_done & r_rx_valid & ~rx_ready;

  // Frame state, bit counter and shift register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shreg     <= w_shreg_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Holding register with valid/ready handshake and sticky overrun flag
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data  <= w_shreg_next;
        r_rx_valid <= 1'b1;
      end else if (w_drain) begin
        r_rx_valid <= 1'b0;
      end
      // Setting wins over a simultaneous clear.
      if (w_overrun_set)  r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = (r_state == ST_SHIFT);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_sipo_rx.sv
// tb_spi_sipo_rx: self-checking bench for spi_sipo_rx.
// Expected words go into a scoreboard queue when their last bit is driven.
// A monitor pops and compares each word accepted downstream. Single-frame
// cases come from a vector table; multi-cycle corner cases are written out
// as hand sequences.
module tb_spi_sipo_rx;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clock = 1'b0;
  logic          n_reset;
  logic          sclk, cs_n, mosi;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic          busy, overrun, frame_err, clr_flags;

  int checks   = 0;
  int failures = 0;
  int n_ferr   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] data;
    int            nbits;
    bit            exp_word;
    bit            exp_ferr;
  } vec_t;
  vec_t vecs[6];

  spi_sipo_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clock(clock), .n_reset(n_reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .clr_flags(clr_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive the top nbits of data, MSB first, 4 clocks per sclk phase
  task automatic send_bits(input logic [DW-1:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[DW-1-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: compare every accepted word; track frame_err pulses
  logic ferr_prev = 1'b0;
  always @(negedge clock) begin
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0h expected none", rx_data);
      end else begin
        check("rx_word", rx_data, exp_q.pop_front());
      end
    end
    if (ferr_prev) check("frame_err_one_cycle", frame_err, 0);
    if (frame_err && !ferr_prev) n_ferr++;
    ferr_prev = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ferr0;
    vecs[0] = '{8'h00, 8, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8, 1'b1, 1'b0};
    vecs[2] = '{8'h7E, 8, 1'b1, 1'b0};
    vecs[3] = '{8'hE8, 5, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 8, 1'b1, 1'b0};
    vecs[5] = '{8'h40, 3, 1'b0, 1'b1};

    n_reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_ready = 1'b0; clr_flags = 1'b0;

    // 1. Reset then idle
    tick(3);
    n_reset = 1'b1;
    tick(5);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_data", rx_data, 0);

    // 2. Single byte 0xA5 with latency. Counting the clock period in which
    // the pin rises as cycle 1, rx_valid is high in cycle SS+2 only.
    rx_ready = 1'b1;
    ferr0 = n_ferr;
    frame_start();
    check("busy_in_frame", busy, 1);
    send_bits(8'hA5, 7);
    mosi = 1'b1;
    tick(4);
    exp_q.push_back(8'hA5);
    sclk = 1'b1;
    tick(SS);
    check("lat_valid_early", rx_valid, 0);
    tick(1);
    check("lat_valid_on_time", rx_valid, 1);
    check("lat_data", rx_data, 8'hA5);
    tick(1);
    check("lat_valid_one_pulse", rx_valid, 0);
    tick(2);
    sclk = 1'b0;
    tick(4);
    frame_end();
    drain("a5_drained");
    check("a5_no_ferr", n_ferr - ferr0, 0);
    check("a5_busy_after", busy, 0);

    // Table: single frames, some truncated
    for (int v = 0; v < 6; v++) begin
      ferr0 = n_ferr;
      frame_start();
      if (vecs[v].exp_word) begin
        send_bits(vecs[v].data, vecs[v].nbits - 1);
        exp_q.push_back(vecs[v].data);
        send_bits(vecs[v].data << (vecs[v].nbits - 1), 1);
      end else begin
        send_bits(vecs[v].data, vecs[v].nbits);
      end
      frame_end();
      drain($sformatf("vec%0d_drained", v));
      check($sformatf("vec%0d_ferr", v), n_ferr - ferr0, 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_valid", v), rx_valid, 0);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // 3. Three words under one chip select
    ferr0 = n_ferr;
    frame_start();
    exp_q.push_back(8'h3C); send_bits(8'h3C, 8);
    exp_q.push_back(8'hFF); send_bits(8'hFF, 8);
    exp_q.push_back(8'h01); send_bits(8'h01, 8);
    frame_end();
    drain("multi_drained");
    check("multi_no_ferr", n_ferr - ferr0, 0);

    // 4. Overrun with rx_ready held low
    rx_ready = 1'b0;
    frame_start();
    send_bits(8'h11, 8);
    tick(4);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_flag", overrun, 0);
    send_bits(8'h22, 8);
    frame_end();
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_flag_set", overrun, 1);
    check("ovr_still_valid", rx_valid, 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    check("ovr_cleared", overrun, 0);
    check("ovr_valid_kept", rx_valid, 1);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_valid_drained", rx_valid, 0);
    drain("ovr_drained");

    // 6. Reset in the middle of a frame
    ferr0 = n_ferr;
    frame_start();
    send_bits(8'hC3, 4);
    check("pre_reset_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", rx_valid, 0);
    check("rst_mid_data", rx_data, 0);
    check("rst_mid_overrun", overrun, 0);
    cs_n = 1'b1;
    tick(3);
    n_reset = 1'b1;
    tick(4);
    frame_start();
    send_bits(8'h96, 7);
    exp_q.push_back(8'h96);
    send_bits(8'h96 << 7, 1);
    frame_end();
    drain("post_reset_drained");
    check("post_reset_no_ferr", n_ferr - ferr0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
